reg_bus_ctrl: RTL and testbench

Bus-side controller for a bank of peripheral registers: read-only status registers (peripheral -> core) and write registers (core -> peripheral).
- Accepts single-cycle read/write requests from the core bus.
- Decodes the address into one-hot read-enable (reg_re) and write-enable (reg_we) strobes, one bit per register slot.
- Samples the OR-combined register read data and returns it with a one-cycle acknowledge.
- Each read-only register freezes its content while its re is high and drives zero when re is low. The bank's outputs are OR-reduced externally into reg_rdata_or.

---
 rtl/reg_bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_reg_bus_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/reg_bus_ctrl.sv
// Bus-side controller for a peripheral register bank: decodes single-cycle core requests
// into one-hot slot strobes and returns a one-cycle ack. Optional read wait: REG_BUS_CTRL_WAIT_EN.
module reg_bus_ctrl #(
    parameter int BW       = 32,
    parameter int AW       = 4,
    parameter int NREG     = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   bus_addr,
    input  logic            bus_rd,
    input  logic            bus_wr,
    input  logic [BW-1:0]   bus_wdata,
    output logic [BW-1:0]   bus_rdata,
    output logic            bus_ack,
    output logic            bus_err,
    output logic            busy,
    output logic [NREG-1:0] reg_re,
    output logic [NREG-1:0] reg_we,
    output logic [BW-1:0]   reg_wdata,
    input  logic [BW-1:0]   reg_rdata_or,
    output logic [1:0]      dbg_state
);

`ifdef REG_BUS_CTRL_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    // Extra read-strobe hold cycles actually in effect; zero makes S_WAIT unreachable.
    localparam int          WAIT_N = WAIT_EN ? WAIT_CYC : 0;
    localparam int          CW     = (WAIT_N > 1) ? $clog2(WAIT_N) : 1;
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Handshake: a request is taken only on an edge where busy=0 and bus_rd|bus_wr=1;
    // its completion is the single-cycle bus_ack pulse, with bus_rdata/bus_err valid only then.
    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_addr;
    logic            r_is_rd;
    logic            r_err;
    logic [BW-1:0]   r_wdata;
    logic [BW-1:0]   r_rdata;
    logic [CW-1:0]   r_wait_cnt;

    logic            w_req_any;
    logic            w_req_both;
    logic            w_addr_bad;
    logic            w_capture;
    logic            w_cnt_inc;
    logic            w_strobe_win;

    assign w_req_any  = bus_rd | bus_wr;
    assign w_req_both = bus_rd & bus_wr;
    assign w_addr_bad = {1'b0, bus_addr} >= NREG_W;

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_both) begin
                    w_next = S_RESP;
                end else if (w_req_any) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_is_rd && (WAIT_N > 0)) begin
                    w_next = S_WAIT;
                end else begin
                    w_next    = S_RESP;
                    w_capture = r_is_rd;
                end
            end
            S_WAIT: begin
                // Read data is sampled on the last cycle the strobe is held.
                if (r_wait_cnt == CW'(WAIT_N - 1)) begin
                    w_next    = S_RESP;
                    w_capture = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_is_rd    <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req_any) begin
                r_addr  <= bus_addr;
                r_is_rd <= bus_rd & ~bus_wr;
                r_err   <= w_req_both | w_addr_bad;
                if (bus_wr && !bus_rd) begin
                    r_wdata <= bus_wdata;
                end
            end
            if (w_capture) begin
                r_rdata <= reg_rdata_or;
            end
            if (r_state != S_WAIT) begin
                r_wait_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
        end
    end

    // Address compare against each slot index also rejects out-of-range addresses.
    assign w_strobe_win = (r_state == S_ACCESS) || (r_state == S_WAIT);

    always_comb begin
        reg_re = '0;
        reg_we = '0;
        for (int i = 0; i < NREG; i++) begin
            reg_re[i] = w_strobe_win && r_is_rd && (r_addr == AW'(i));
            reg_we[i] = (r_state == S_ACCESS) && !r_is_rd && (r_addr == AW'(i));
        end
    end

    assign bus_ack   = (r_state == S_RESP);
    assign bus_err   = bus_ack & r_err;
    assign bus_rdata = (bus_ack && r_is_rd && !r_err) ? r_rdata : '0;
    assign busy      = (r_state != S_IDLE);
    assign reg_wdata = r_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Self-checking bench for reg_bus_ctrl: directed cases plus randomized requests
// checked cycle-by-cycle against a transaction-level timing model.
module tb_reg_bus_ctrl;
  localparam int BW   = 32;
  localparam int AW   = 4;
  localparam int NREG = 8;
`ifdef REG_BUS_CTRL_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   bus_addr;
  logic            bus_rd;
  logic            bus_wr;
  logic [BW-1:0]   bus_wdata;
  logic [BW-1:0]   bus_rdata;
  logic            bus_ack;
  logic            bus_err;
  logic            busy;
  logic [NREG-1:0] reg_re;
  logic [NREG-1:0] reg_we;
  logic [BW-1:0]   reg_wdata;
  logic [BW-1:0]   reg_rdata_or;
  logic [1:0]      dbg_state;

  logic [BW-1:0]   slot_val [NREG];
  int              n_vec = 0;
  int              n_err = 0;

  reg_bus_ctrl #(.BW(BW), .AW(AW), .NREG(NREG), .WAIT_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .busy(busy), .reg_re(reg_re), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .reg_rdata_or(reg_rdata_or), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // register bank: each slot drives its value only while its read enable is high
  always_comb begin
    reg_rdata_or = '0;
    for (int i = 0; i < NREG; i++) begin
      if (reg_re[i]) reg_rdata_or = reg_rdata_or | slot_val[i];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rdata"}, bus_rdata, 0);
    check_eq({tag, "_ack"}, 32'(bus_ack), 0);
    check_eq({tag, "_err"}, 32'(bus_err), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_re"}, 32'(reg_re), 0);
    check_eq({tag, "_we"}, 32'(reg_we), 0);
  endtask

  // One transaction; expectations come from the timing rules:
  // strobes in cycles 1..1+W (read) or cycle 1 (write), ack in the cycle after the strobes,
  // dual request acks in cycle 1. Cycle k = interval after the k-th edge following the request.
  task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [BW-1:0] wd, input bit inject, input logic [AW-1:0] inj_addr);
    bit            valid, both, exp_err;
    int            ack_cyc, re_last;
    logic [BW-1:0] exp_rd;
    logic [7:0]    e_re, e_we;
    valid   = (int'(addr) < NREG);
    both    = rd && wr;
    exp_err = both || !valid;
    ack_cyc = both ? 1 : (rd ? 2 + W : 2);
    re_last = 1 + W;
    exp_rd  = (rd && !wr && valid) ? slot_val[addr] : '0;
    @(negedge clk);
    bus_rd = rd; bus_wr = wr; bus_addr = addr; bus_wdata = wd;
    for (int k = 1; k <= ack_cyc + 1; k++) begin
      @(negedge clk);
      e_re = (rd && !wr && valid && k <= re_last) ? 8'(1 << addr) : 8'h00;
      e_we = (wr && !rd && valid && k == 1) ? 8'(1 << addr) : 8'h00;
      check_eq($sformatf("re_c%0d", k), 32'(reg_re), 32'(e_re));
      check_eq($sformatf("we_c%0d", k), 32'(reg_we), 32'(e_we));
      if (e_we != 0) check_eq("wdata", reg_wdata, wd);
      check_eq($sformatf("ack_c%0d", k), 32'(bus_ack), 32'(k == ack_cyc));
      check_eq($sformatf("busy_c%0d", k), 32'(busy), 32'(k <= ack_cyc));
      check_eq($sformatf("rdata_c%0d", k), bus_rdata, (k == ack_cyc) ? exp_rd : '0);
      check_eq($sformatf("err_c%0d", k), 32'(bus_err), 32'((k == ack_cyc) && exp_err));
      if (k == 1 && inject) begin
        bus_rd = 1'b1; bus_wr = 1'b0; bus_addr = inj_addr;
      end else begin
        bus_rd = 1'b0; bus_wr = 1'b0;
      end
    end
  endtask

  initial begin
    int op;
    logic [AW-1:0] a;
    rst_n = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
    for (int i = 0; i < NREG; i++) slot_val[i] = $urandom;
    slot_val[3] = 32'hA5A5_0003;

    // reset then idle
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    check_eq("rst_wdata", reg_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    // directed cases
    do_req(1'b1, 1'b0, 4'd3, '0, 1'b0, '0);
    do_req(1'b0, 1'b1, 4'd5, 32'h1234_5678, 1'b0, '0);
    do_req(1'b1, 1'b0, 4'd9, '0, 1'b0, '0);
    do_req(1'b1, 1'b1, 4'd2, 32'hDEAD_BEEF, 1'b0, '0);
    do_req(1'b1, 1'b0, 4'd1, '0, 1'b1, 4'd2);
    do_req(1'b0, 1'b1, 4'd7, 32'h0BAD_F00D, 1'b1, 4'd0);
    do_req(1'b1, 1'b0, 4'd0, '0, 1'b0, '0);

    // reset during the access phase of a read
    @(negedge clk);
    bus_rd = 1'b1; bus_addr = 4'd4;
    @(negedge clk);
    bus_rd = 1'b0;
    check_eq("abort_re_before", 32'(reg_re), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_re_async", 32'(reg_re), 0);
    check_eq("abort_busy_async", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("abort_noack_%0d", k), 32'(bus_ack), 0);
    end

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) slot_val[$urandom_range(0, NREG - 1)] = $urandom;
      op = $urandom_range(0, 9);
      a  = AW'($urandom_range(0, NREG - 1));
      case (op)
        0, 1, 2, 3, 4: do_req(1'b1, 1'b0, a, '0, 1'b0, '0);
        5, 6, 7:       do_req(1'b0, 1'b1, a, $urandom, op == 7, AW'($urandom_range(0, 15)));
        8:             do_req(1'b1, 1'b1, a, $urandom, 1'b0, '0);
        default:       do_req(op[0] ? 1'b1 : 1'b0, op[0] ? 1'b0 : 1'b1,
                              AW'($urandom_range(NREG, 15)), $urandom, 1'b0, '0);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
